// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS execute/memory slice: main-control ALU classes,
// R-type funct values and the 4-bit ALU operation codes.
package mips_pkg;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_OR    = 2'b11
    } aluop_e;

    localparam logic [5:0] FUNCT_SLL = 6'h00;
    localparam logic [5:0] FUNCT_SRL = 6'h02;
    localparam logic [5:0] FUNCT_JR  = 6'h08;
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_NOR = 6'h27;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    localparam logic [3:0] ALU_CTL_AND = 4'b0000;
    localparam logic [3:0] ALU_CTL_OR  = 4'b0001;
    localparam logic [3:0] ALU_CTL_ADD = 4'b0010;
    localparam logic [3:0] ALU_CTL_SUB = 4'b0110;
    localparam logic [3:0] ALU_CTL_SLT = 4'b0111;
    localparam logic [3:0] ALU_CTL_SLL = 4'b1000;
    localparam logic [3:0] ALU_CTL_SRL = 4'b1001;
    localparam logic [3:0] ALU_CTL_NOR = 4'b1100;

endpackage

// File: rtl/mips_dmem.sv
// Word-addressed data memory: synchronous write and clear, combinational read
// that is forced to zero while reset is asserted.
module mips_dmem #(
    parameter int DMEM_WORDS = 256,
    parameter int DATA_W     = 32,
    parameter int AW         = $clog2(DMEM_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DMEM_WORDS];
    logic              wr_en_d;

    always_comb begin
        wr_en_d = reset & we;
    end

    // Clearing wins over a write presented in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DMEM_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_d) begin
            mem_q[idx] <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        if (re && reset) begin
            rdata = mem_q[idx];
        end
    end

endmodule

// File: rtl/mips_exec_mem_unit.sv
// Single-cycle MIPS execute + memory slice: ALU control decode, 32-bit ALU and data memory.
// Optional macro ALU_OVF_EN adds an "overflow" output flagging signed ADD/SUB overflow.
module mips_exec_mem_unit
    import mips_pkg::*;
#(
    parameter int DMEM_WORDS = 256,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        aluop,
    input  logic [5:0]        funct,
    input  logic [4:0]        shamt,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              memread,
    input  logic              memwrite,
    output logic [3:0]        alu_ctl,
    output logic              jump_reg,
    output logic [DATA_W-1:0] alu_result,
    output logic              zero,
    output logic [DATA_W-1:0] mem_rdata
`ifdef ALU_OVF_EN
    ,
    output logic              overflow
`endif
);

    localparam int AW = $clog2(DMEM_WORDS);

    always_comb begin
        alu_ctl  = ALU_CTL_ADD;
        jump_reg = 1'b0;
        case (aluop_e'(aluop))
            ALUOP_ADD: alu_ctl = ALU_CTL_ADD;
            ALUOP_SUB: alu_ctl = ALU_CTL_SUB;
            ALUOP_OR:  alu_ctl = ALU_CTL_OR;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: alu_ctl = ALU_CTL_ADD;
                    FUNCT_SUB: alu_ctl = ALU_CTL_SUB;
                    FUNCT_AND: alu_ctl = ALU_CTL_AND;
                    FUNCT_OR:  alu_ctl = ALU_CTL_OR;
                    FUNCT_NOR: alu_ctl = ALU_CTL_NOR;
                    FUNCT_SLT: alu_ctl = ALU_CTL_SLT;
                    FUNCT_SLL: alu_ctl = ALU_CTL_SLL;
                    FUNCT_SRL: alu_ctl = ALU_CTL_SRL;
                    FUNCT_JR: begin
                        alu_ctl  = ALU_CTL_ADD;
                        jump_reg = 1'b1;
                    end
                    default:   alu_ctl = ALU_CTL_ADD;
                endcase
            end
            default: alu_ctl = ALU_CTL_ADD;
        endcase
    end

    always_comb begin
        alu_result = '0;
        case (alu_ctl)
            ALU_CTL_ADD: alu_result = op_a + op_b;
            ALU_CTL_SUB: alu_result = op_a - op_b;
            ALU_CTL_AND: alu_result = op_a & op_b;
            ALU_CTL_OR:  alu_result = op_a | op_b;
            ALU_CTL_NOR: alu_result = ~(op_a | op_b);
            ALU_CTL_SLT: alu_result = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_CTL_SLL: alu_result = op_b << shamt;
            ALU_CTL_SRL: alu_result = op_b >> shamt;
            default:     alu_result = '0;
        endcase
    end

    assign zero = (alu_result == '0);

`ifdef ALU_OVF_EN
    // Overflow when operand signs make the result sign impossible; SUB sees ~b's sign.
    always_comb begin
        overflow = 1'b0;
        if (alu_ctl == ALU_CTL_ADD) begin
            overflow = (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                       (alu_result[DATA_W-1] != op_a[DATA_W-1]);
        end else if (alu_ctl == ALU_CTL_SUB) begin
            overflow = (op_a[DATA_W-1] != op_b[DATA_W-1]) &&
                       (alu_result[DATA_W-1] != op_a[DATA_W-1]);
        end
    end
`endif

    mips_dmem #(
        .DMEM_WORDS (DMEM_WORDS),
        .DATA_W     (DATA_W),
        .AW         (AW)
    ) u_dmem (
        .clk   (clk),
        .reset (reset),
        .we    (memwrite),
        .re    (memread),
        .idx   (alu_result[AW+1:2]),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_mips_exec_mem_unit.sv
// Directed bench for mips_exec_mem_unit: ALU control/ALU vectors, memory write/read, reset clear.
// Overflow checks are compiled in when ALU_OVF_EN is defined.
module tb_mips_exec_mem_unit;

    logic        clk;
    logic        reset;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] mem_wdata;
    logic        memread;
    logic        memwrite;
    logic [3:0]  alu_ctl;
    logic        jump_reg;
    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] mem_rdata;
`ifdef ALU_OVF_EN
    logic        overflow;
`endif

    int compared;
    int mismatched;

    mips_exec_mem_unit #(
        .DMEM_WORDS (256),
        .DATA_W     (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .aluop      (aluop),
        .funct      (funct),
        .shamt      (shamt),
        .op_a       (op_a),
        .op_b       (op_b),
        .mem_wdata  (mem_wdata),
        .memread    (memread),
        .memwrite   (memwrite),
        .alu_ctl    (alu_ctl),
        .jump_reg   (jump_reg),
        .alu_result (alu_result),
        .zero       (zero),
        .mem_rdata  (mem_rdata)
`ifdef ALU_OVF_EN
        ,
        .overflow   (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                                 input logic [31:0] a, input logic [31:0] b);
        aluop = op;
        funct = fn;
        shamt = sh;
        op_a  = a;
        op_b  = b;
        #1;
    endtask

    task automatic runVector(input string tag, input logic [1:0] op, input logic [5:0] fn,
                             input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] exp_ctl, input logic exp_jr, input logic [31:0] exp_res);
        applyStimulus(op, fn, sh, a, b);
        checkOutput({tag, ".alu_ctl"},  {28'd0, alu_ctl},  {28'd0, exp_ctl});
        checkOutput({tag, ".jump_reg"}, {31'd0, jump_reg}, {31'd0, exp_jr});
        checkOutput({tag, ".result"},   alu_result,        exp_res);
        checkOutput({tag, ".zero"},     {31'd0, zero},     {31'd0, (exp_res == 32'd0)});
    endtask

    // Puts a byte address on alu_result via ADD a+0.
    task automatic setAddr(input logic [31:0] addr);
        applyStimulus(2'b00, 6'h00, 5'd0, addr, 32'd0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b0;
        memread    = 1'b1;
        memwrite   = 1'b0;
        mem_wdata  = 32'd0;
        applyStimulus(2'b00, 6'h00, 5'd0, 32'h10, 32'd0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst.rdata_forced", mem_rdata, 32'd0);
        reset = 1'b1;
        #1;
        checkOutput("rst.cleared", mem_rdata, 32'd0);

        runVector("sub_eq",   2'b10, 6'h22, 5'd0, 32'd5,        32'd5,        4'b0110, 1'b0, 32'd0);
        runVector("slt_neg",  2'b10, 6'h2A, 5'd0, 32'hFFFFFFFF, 32'd1,        4'b0111, 1'b0, 32'd1);
        runVector("slt_pos",  2'b10, 6'h2A, 5'd0, 32'd1,        32'hFFFFFFFF, 4'b0111, 1'b0, 32'd0);
        runVector("sll4",     2'b10, 6'h00, 5'd4, 32'h1234,     32'd1,        4'b1000, 1'b0, 32'h10);
        runVector("sll0",     2'b10, 6'h00, 5'd0, 32'd0,        32'hABCD,     4'b1000, 1'b0, 32'hABCD);
        runVector("srl8",     2'b10, 6'h02, 5'd8, 32'd0,        32'h80000000, 4'b1001, 1'b0, 32'h00800000);
        runVector("jr",       2'b10, 6'h08, 5'd0, 32'h100,      32'd4,        4'b0010, 1'b1, 32'h104);
        runVector("add_jrfn", 2'b00, 6'h08, 5'd0, 32'd3,        32'd4,        4'b0010, 1'b0, 32'd7);
        runVector("sub_cls",  2'b01, 6'h00, 5'd0, 32'd3,        32'd5,        4'b0110, 1'b0, 32'hFFFFFFFE);
        runVector("or_cls",   2'b11, 6'h00, 5'd0, 32'hF0,       32'h0F,       4'b0001, 1'b0, 32'hFF);
        runVector("and",      2'b10, 6'h24, 5'd0, 32'hFF00FF00, 32'h0FF00FF0, 4'b0000, 1'b0, 32'h0F000F00);
        runVector("or",       2'b10, 6'h25, 5'd0, 32'hFF00FF00, 32'h0FF00FF0, 4'b0001, 1'b0, 32'hFFF0FFF0);
        runVector("nor",      2'b10, 6'h27, 5'd0, 32'hFF00FF00, 32'h0FF00FF0, 4'b1100, 1'b0, 32'h000F000F);
        runVector("add_wrap", 2'b10, 6'h20, 5'd0, 32'hFFFFFFFF, 32'd1,        4'b0010, 1'b0, 32'd0);
        runVector("unlisted", 2'b10, 6'h3F, 5'd0, 32'd2,        32'd3,        4'b0010, 1'b0, 32'd5);

`ifdef ALU_OVF_EN
        applyStimulus(2'b10, 6'h20, 5'd0, 32'h7FFFFFFF, 32'd1);
        checkOutput("ovf.add_res", alu_result, 32'h80000000);
        checkOutput("ovf.add", {31'd0, overflow}, 32'd1);
        applyStimulus(2'b01, 6'h00, 5'd0, 32'd0, 32'd1);
        checkOutput("ovf.sub", {31'd0, overflow}, 32'd0);
        applyStimulus(2'b01, 6'h00, 5'd0, 32'h80000000, 32'd1);
        checkOutput("ovf.sub_neg", {31'd0, overflow}, 32'd1);
        applyStimulus(2'b10, 6'h25, 5'd0, 32'h7FFFFFFF, 32'd1);
        checkOutput("ovf.or", {31'd0, overflow}, 32'd0);
`endif

        // Write DEADBEEF at 0x10; old contents visible until the edge.
        @(negedge clk);
        setAddr(32'h10);
        mem_wdata = 32'hDEADBEEF;
        memwrite  = 1'b1;
        memread   = 1'b1;
        #1;
        checkOutput("mem.old_word", mem_rdata, 32'd0);
        @(negedge clk);
        memwrite = 1'b0;
        checkOutput("mem.new_word", mem_rdata, 32'hDEADBEEF);
        setAddr(32'h13);
        checkOutput("mem.rd_0x13", mem_rdata, 32'hDEADBEEF);
        memread = 1'b0;
        #1;
        checkOutput("mem.rd_off", mem_rdata, 32'd0);
        memread = 1'b1;

        setAddr(32'h14);
        mem_wdata = 32'h12345678;
        memwrite  = 1'b1;
        @(negedge clk);
        memwrite = 1'b0;
        #1;
        checkOutput("mem.rd_0x14", mem_rdata, 32'h12345678);
        setAddr(32'h10);
        checkOutput("mem.neighbour", mem_rdata, 32'hDEADBEEF);
        setAddr(32'h410);
        checkOutput("mem.wrap", mem_rdata, 32'hDEADBEEF);

        // Reset for one cycle while attempting a write to 0x20.
        @(negedge clk);
        setAddr(32'h20);
        mem_wdata = 32'h55555555;
        memwrite  = 1'b1;
        reset     = 1'b0;
        #1;
        checkOutput("rst.rd_forced", mem_rdata, 32'd0);
        @(negedge clk);
        reset    = 1'b1;
        memwrite = 1'b0;
        #1;
        checkOutput("rst.wr_ignored", mem_rdata, 32'd0);
        setAddr(32'h10);
        checkOutput("rst.clr_0x10", mem_rdata, 32'd0);
        setAddr(32'h14);
        checkOutput("rst.clr_0x14", mem_rdata, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
